// File: rtl/vend_pkg.sv
// Shared types and constants for the vend_ctrl coin/vend sequencer.
// The optional change payout (VEND_CHANGE_EN) is selected in vend_ctrl.sv.
package vend_pkg;

  localparam int CREDIT_W     = 8;
  localparam int PRICE_DEF    = 20;
  localparam int COIN_A_DEF   = 5;
  localparam int COIN_B_DEF   = 10;
  localparam int DEBOUNCE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

endpackage

// File: rtl/vend_ctrl_debounce.sv
// Active-low pushbutton front end: 2-flop synchronizer plus a counter of
// consecutive low samples; one press event per press.
module coin_debounce
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The counter saturates at CNT_MAX, so a held button cannot re-trigger
  // until a high sample clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= pb;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt   <= cnt + 1'b1;
        press <= (cnt == CNT_MAX - 1'b1);
      end
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Coin-acceptance and vend sequencer: pending flags, B-over-A arbiter, credit
// datapath and FSM. Define VEND_CHANGE_EN to pay leftover credit out as change.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE           = PRICE_DEF,
  parameter int COIN_A          = COIN_A_DEF,
  parameter int COIN_B          = COIN_B_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pb0,
  input  logic                pb1,
  output logic [7:0]          leds,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic                change,
  output logic                reject,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] COIN_A_C = CREDIT_W'(COIN_A);
  localparam logic [CREDIT_W-1:0] COIN_B_C = CREDIT_W'(COIN_B);

  state_t            state;
  logic              press_a;
  logic              press_b;
  logic              pa;
  logic              pb;
  logic [CREDIT_W:0] coin_val;
  logic [CREDIT_W:0] sum;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst   (rst),
    .pb    (pb0),
    .press (press_a)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst   (rst),
    .pb    (pb1),
    .press (press_b)
  );

  // The top bit of the 9-bit sum flags a coin that would overflow credit.
  always_comb begin
    coin_val = pb ? {1'b0, COIN_B_C} : {1'b0, COIN_A_C};
    sum      = {1'b0, credit} + coin_val;
  end

`ifndef VEND_CHANGE_EN
  assign change = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      credit <= '0;
      leds   <= '0;
      vend   <= 1'b0;
      reject <= 1'b0;
      busy   <= 1'b0;
      pa     <= 1'b0;
      pb     <= 1'b0;
`ifdef VEND_CHANGE_EN
      change <= 1'b0;
`endif
    end else begin
      vend   <= 1'b0;
      reject <= 1'b0;
      pa     <= pa | press_a;
      pb     <= pb | press_b;
      case (state)
        IDLE: begin
          if (credit >= PRICE_C) begin
            state  <= VEND;
            vend   <= 1'b1;
            busy   <= 1'b1;
            credit <= credit - PRICE_C;
            leds   <= leds + 1'b1;
          end else if (pb || pa) begin
            if (pb) pb <= 1'b0;
            else    pa <= 1'b0;
            if (sum[CREDIT_W]) reject <= 1'b1;
            else               credit <= sum[CREDIT_W-1:0];
          end
        end
        VEND: begin
`ifdef VEND_CHANGE_EN
          if (credit != '0) begin
            state <= CHANGE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
`ifdef VEND_CHANGE_EN
        // change itself marks the pulse cycle; a cleared change is the gap.
        // Stopping below COIN_A guards against coin values that are not multiples of it.
        CHANGE: begin
          if (change) begin
            change <= 1'b0;
          end else if (credit < COIN_A_C) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            change <= 1'b1;
            credit <= credit - COIN_A_C;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: vector table, hand sequences for timing
// corners, and random presses checked against an arithmetic credit model.
module tb_vend_ctrl;

  localparam int DEB = 4;
`ifdef VEND_CHANGE_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst  [3];
  logic       pa_n [3];
  logic       pb_n [3];
  wire  [7:0] leds   [3];
  wire  [7:0] credit [3];
  wire        vend   [3];
  wire        change [3];
  wire        reject [3];
  wire        busy   [3];

  int vectors = 0;
  int miscompares = 0;
  int nv [3] = '{0, 0, 0};
  int nc [3] = '{0, 0, 0};
  int nr [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  // u0: default pricing; u1: PRICE 255 for overflow; u2: PRICE 10 / COIN_B 20 for reset mid-payout
  vend_ctrl #(.DEBOUNCE_CYCLES(DEB)) u0 (
    .clk(clk), .rst(rst[0]), .pb0(pa_n[0]), .pb1(pb_n[0]), .leds(leds[0]), .credit(credit[0]),
    .vend(vend[0]), .change(change[0]), .reject(reject[0]), .busy(busy[0]));
  vend_ctrl #(.PRICE(255), .DEBOUNCE_CYCLES(DEB)) u1 (
    .clk(clk), .rst(rst[1]), .pb0(pa_n[1]), .pb1(pb_n[1]), .leds(leds[1]), .credit(credit[1]),
    .vend(vend[1]), .change(change[1]), .reject(reject[1]), .busy(busy[1]));
  vend_ctrl #(.PRICE(10), .COIN_B(20), .DEBOUNCE_CYCLES(DEB)) u2 (
    .clk(clk), .rst(rst[2]), .pb0(pa_n[2]), .pb1(pb_n[2]), .leds(leds[2]), .credit(credit[2]),
    .vend(vend[2]), .change(change[2]), .reject(reject[2]), .busy(busy[2]));

  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (vend[u] === 1'b1)   nv[u]++;
      if (change[u] === 1'b1) nc[u]++;
      if (reject[u] === 1'b1) nr[u]++;
      if (vend[u] === 1'b1 || change[u] === 1'b1 || reject[u] === 1'b1) begin
        vectors++;
        if ((vend[u] && change[u]) || (vend[u] && reject[u]) || (change[u] && reject[u])) begin
          miscompares++;
          $display("FAIL exclusive_pulses u%0d: vend=%b change=%b reject=%b, at most one allowed",
                   u, vend[u], change[u], reject[u]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== 32'(exp)) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input int u, input bit a, input bit b, input int hold, input int rest);
    if (a) pa_n[u] = 1'b0;
    if (b) pb_n[u] = 1'b0;
    repeat (hold) step();
    pa_n[u] = 1'b1;
    pb_n[u] = 1'b1;
    repeat (rest) step();
  endtask

  task automatic do_reset(input int u);
    pa_n[u] = 1'b1;
    pb_n[u] = 1'b1;
    rst[u] = 1'b1;
    step();
    step();
    rst[u] = 1'b0;
  endtask

  // Reference model: coins in arrival order, vend whenever credit reaches
  // the price, leftover paid out as COIN_A units when change is enabled.
  int m_credit, m_leds, m_v, m_c, m_r;

  task automatic model_coin(input int v);
    if (m_credit + v > 255) m_r++;
    else m_credit += v;
    while (m_credit >= 20) begin
      m_credit -= 20;
      m_leds = (m_leds + 1) % 256;
      m_v++;
      if (CHG) begin
        m_c += m_credit / 5;
        m_credit = 0;
      end
    end
  endtask

  typedef struct {
    bit a;
    bit b;
    int hold;
    int exp_credit;
    int exp_leds;
  } vec_t;

  vec_t tbl [8];
  int   base_v, base_c, base_r, kind, hold, found;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 10, 5, 0};
    tbl[1] = '{1'b1, 1'b0, 3, 5, 0};
    tbl[2] = '{1'b0, 1'b1, 4, 15, 0};
    tbl[3] = '{1'b1, 1'b1, 6, CHG ? 5 : 10, 1};
    tbl[4] = '{1'b0, 1'b1, 5, CHG ? 15 : 0, CHG ? 1 : 2};
    tbl[5] = '{1'b1, 1'b0, 7, CHG ? 0 : 5, 2};
    tbl[6] = '{1'b1, 1'b1, 4, CHG ? 15 : 0, CHG ? 2 : 3};
    tbl[7] = '{1'b1, 1'b0, 2, CHG ? 15 : 0, CHG ? 2 : 3};

    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1;
      pa_n[u] = 1'b1;
      pb_n[u] = 1'b1;
    end
    repeat (3) step();
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;

    check("reset_leds", leds[0], 0);
    check("reset_credit", credit[0], 0);
    check("reset_vend", vend[0], 0);
    check("reset_change", change[0], 0);
    check("reset_reject", reject[0], 0);
    check("reset_busy", busy[0], 0);

    // Single coin: credit moves on edge DEB+4 counted from the first low sample edge
    pa_n[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == DEB + 3) check("single_coin_before", credit[0], 0);
      if (k == DEB + 4) check("single_coin_at", credit[0], 5);
    end
    pa_n[0] = 1'b1;
    repeat (10) step();
    check("single_coin_once", credit[0], 5);
    check("single_coin_no_vend", nv[0], 0);

    // Exact-price vend timing
    press(0, 1'b1, 1'b0, 4, 16);
    press(0, 1'b1, 1'b0, 4, 16);
    check("three_coins", credit[0], 15);
    pa_n[0] = 1'b0;
    found = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 4) pa_n[0] = 1'b1;
      if (credit[0] == 8'd20) begin
        found = 1;
        break;
      end
    end
    pa_n[0] = 1'b1;
    check("reach_price", found, 1);
    step();
    check("vend_pulse", vend[0], 1);
    check("vend_credit", credit[0], 0);
    check("vend_leds", leds[0], 1);
    check("vend_busy", busy[0], 1);
    step();
    check("vend_one_cycle", vend[0], 0);
    check("vend_busy_clear", busy[0], 0);
    repeat (6) step();
    check("exact_no_change", nc[0], 0);

    // Vector table from a fresh reset
    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      press(0, tbl[i].a, tbl[i].b, tbl[i].hold, 20);
      check($sformatf("tbl%0d_credit", i), credit[0], tbl[i].exp_credit);
      check($sformatf("tbl%0d_leds", i), leds[0], tbl[i].exp_leds);
    end

    // Overpay: 15 + B -> 25, vend, leftover 5
    do_reset(0);
    repeat (3) press(0, 1'b1, 1'b0, 4, 12);
    pb_n[0] = 1'b0;
    found = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 4) pb_n[0] = 1'b1;
      if (credit[0] == 8'd25) begin
        found = 1;
        break;
      end
    end
    pb_n[0] = 1'b1;
    check("overpay_reach", found, 1);
    step();
    check("overpay_vend", vend[0], 1);
    check("overpay_credit_after_vend", credit[0], 5);
    base_c = nc[0];
    repeat (8) step();
    check("overpay_change_count", nc[0] - base_c, CHG ? 1 : 0);
    check("overpay_final_credit", credit[0], CHG ? 0 : 5);
    check("overpay_busy_end", busy[0], 0);

    // Random presses against the model
    do_reset(0);
    m_credit = 0; m_leds = 0; m_v = 0; m_c = 0; m_r = 0;
    base_v = nv[0]; base_c = nc[0]; base_r = nr[0];
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      hold = $urandom_range(1, 8);
      press(0, kind != 1, kind != 0, hold, 20);
      if (hold >= DEB) begin
        if (kind != 0) model_coin(10);
        if (kind != 1) model_coin(5);
      end
      check($sformatf("rnd%0d_credit", i), credit[0], m_credit);
      check($sformatf("rnd%0d_leds", i), leds[0], m_leds);
      check($sformatf("rnd%0d_vends", i), nv[0] - base_v, m_v);
      check($sformatf("rnd%0d_changes", i), nc[0] - base_c, m_c);
      check($sformatf("rnd%0d_rejects", i), nr[0] - base_r, m_r);
    end

    // LED wrap after 256 vends
    do_reset(0);
    base_v = nv[0];
    for (int i = 0; i < 256; i++) begin
      press(0, 1'b0, 1'b1, 4, 8);
      press(0, 1'b0, 1'b1, 4, 8);
      if (i == 254) check("leds_at_255", leds[0], 255);
    end
    check("leds_wrap", leds[0], 0);
    check("wrap_vend_count", nv[0] - base_v, 256);
    check("wrap_credit", credit[0], 0);

    // Overflow on the PRICE=255 instance
    for (int i = 0; i < 25; i++) press(1, 1'b0, 1'b1, 4, 8);
    check("ovf_preset", credit[1], 250);
    base_r = nr[1];
    press(1, 1'b0, 1'b1, 4, 12);
    check("ovf_reject", nr[1] - base_r, 1);
    check("ovf_credit_kept", credit[1], 250);
    check("ovf_no_vend", nv[1], 0);
    press(1, 1'b1, 1'b0, 4, 12);
    check("full_255_vend", nv[1], 1);
    check("full_255_credit", credit[1], 0);
    check("full_255_leds", leds[1], 1);

    // Reset during payout (or during vend without the change option)
    press(2, 1'b1, 1'b0, 4, 10);
    check("u2_credit5", credit[2], 5);
    pb_n[2] = 1'b0;
    repeat (4) step();
    pb_n[2] = 1'b1;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if ((CHG ? change[2] : vend[2]) === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("u2_trigger_seen", found, 1);
    check("u2_credit_at_trigger", credit[2], CHG ? 10 : 15);
    rst[2] = 1'b1;
    step();
    check("u2_rst_leds", leds[2], 0);
    check("u2_rst_credit", credit[2], 0);
    check("u2_rst_vend", vend[2], 0);
    check("u2_rst_change", change[2], 0);
    check("u2_rst_reject", reject[2], 0);
    check("u2_rst_busy", busy[2], 0);
    rst[2] = 1'b0;
    base_v = nv[2];
    base_c = nc[2];
    repeat (12) step();
    check("u2_no_change_after_rst", nc[2] - base_c, 0);
    check("u2_no_vend_after_rst", nv[2] - base_v, 0);
    check("u2_credit_stays_0", credit[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Coin-acceptance and vend sequencer for the board-level coin demo. It takes the two active-low coin push buttons, debounces and arbitrates them, and keeps a credit balance. When credit reaches the item price it issues a vend, counts vends on the LEDs, and optionally pays out change. It sits directly between the pushbutton pins and the LED bank.

## Interface
- `PRICE`, default 20: credit consumed per vend; must be a multiple of `COIN_A`.
- `COIN_A`, default 5: value credited by `pb0`; also the change-pulse unit.
- `COIN_B`, default 10: value credited by `pb1`.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples needed to accept a press. The board build overrides it to 500000.
- `clk` input, 1 bit: the single clock for all logic.
- `rst` input, 1 bit: synchronous, active-high reset.
- `pb0` input, 1 bit: coin A button, active-low, asynchronous to `clk`.
- `pb1` input, 1 bit: coin B button, active-low, asynchronous to `clk`.
- `leds` output, 8 bits: vend count; wraps from 255 to 0.
- `credit` output, 8 bits: current balance.
- `vend` output, 1 bit: one-cycle pulse per vend.
- `change` output, 1 bit: one-cycle pulse per `COIN_A` of change returned.
- `reject` output, 1 bit: one-cycle pulse when a coin would overflow `credit`.
- `busy` output, 1 bit: high in `VEND` and `CHANGE`.

## Operation
- **Reset values:** all outputs 0, `state`=`IDLE`, pending flags 0, debounce counters 0. Synchronizer flops are set to 1 (released).
- **Per-button front end:**
  - 2-flop synchronizer, then a counter of consecutive low samples.
  - When the count reaches `DEBOUNCE_CYCLES`, emit a one-cycle press event.
  - No further event until a high sample clears the counter, so one press gives one event.
- **Pending flags:** each press event sets that button's pending flag (`pa`, `pb`). A flag that is already set stays set; a second event while pending is dropped.
- **`IDLE` state, priority order:**
  1. If `credit` >= `PRICE`, go to `VEND`. No coin is accepted that cycle.
  2. Otherwise, if `pb` is set, accept `COIN_B` and clear `pb`.
  3. Otherwise, if `pa` is set, accept `COIN_A` and clear `pa`.
  - At most one coin is accepted per cycle, so simultaneous presses give B, then A on the next `IDLE` cycle.
- **Accept:** if `credit` + value > 255, pulse `reject`, leave `credit` unchanged, and clear the flag. Otherwise `credit` += value, computed in 9-bit arithmetic.
- **`VEND` state (1 cycle):** `vend`=1, `credit` -= `PRICE`, `leds` += 1. Next state is `CHANGE` if change is enabled and the new credit is nonzero, else `IDLE`.
- **`CHANGE` state:** alternates a pulse cycle and a gap cycle.
  - Pulse cycle: `change`=1 and `credit` -= `COIN_A`.
  - Return to `IDLE` after the gap that follows the pulse which makes `credit` 0.
- **Presses during `VEND`/`CHANGE`:** they still set pending flags and are serviced in `IDLE`.
- **Reset mid-vend or mid-change:** everything is abandoned and no further pulses are emitted; `credit` is cleared.

## Timing
- A press held low from the first sampling edge N updates `credit` at edge N+`DEBOUNCE_CYCLES`+3, provided `state` is `IDLE`.
- Vend decision is taken the cycle after `credit` >= `PRICE` becomes visible. `vend` is high for exactly 1 cycle, and `leds`/`credit` update on the same edge that asserts it.
- Change pulses have a period of 2 cycles and are never back-to-back.
- `reject`, `vend` and `change` are mutually exclusive in any cycle.
- Outputs are registered; there are no combinational paths from input to output.

## Configuration
- `VEND_CHANGE_EN` defined: `CHANGE` state is present, and credit left after a vend is paid out as `change` pulses.
- `VEND_CHANGE_EN` not defined: no `CHANGE` state and `change` is tied to 0. Leftover credit carries forward, and a further vend follows immediately while `credit` >= `PRICE`.

## Structure
- Package `vend_pkg`:
  - state enum `IDLE`/`VEND`/`CHANGE`, 2 bits;
  - default coin and price constants;
  - credit width constant, 8.
- Sub-module `coin_debounce`, instantiated twice: synchronizer, counter and press-event output, parameterised by `DEBOUNCE_CYCLES`.
- The top module holds the pending flags, arbiter, credit datapath and FSM.

## Test plan
- **Single coin:** `pb0` low for 10 cycles then high → `credit` goes 0→5 once at edge `DEBOUNCE_CYCLES`+3; no `vend`.
- **Simultaneous press:** `pb0` and `pb1` low on the same cycle → `credit` 0→10, then →15 on the next cycle; neither is lost.
- **Exact-price vend:** 4×`pb0` presses → `credit` reaches 20, then `vend` pulses 1 cycle later; `credit`=0, `leds`=1, no `change`.
- **Overpay with change (`VEND_CHANGE_EN`):** `credit`=15 plus a `pb1` press → `credit` 25, `vend`, then one `change` pulse; `credit` ends 0.
- **Overflow:** credit preset to 250 (no vend, `PRICE` overridden to 255) plus a `pb1` press → `reject` pulse and `credit` stays 250. Also: `leds` wraps 255→0 after its 256th vend.
- **Reset mid-change:** `rst` asserted during `CHANGE` with 10 credit left → no further `change`; all outputs 0 on the next edge.
